// File: rtl/shoot_game_pkg.sv
// Shared encodings for the shooting-game flow controller: state codes and PS/2 set-2 make codes.
package shoot_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_HIT_PAUSE = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse on its rising edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: start/countdown/play/hit-pause/game-over flow, frame gating, shot arbitration,
// score and lives. All outputs registered, one cycle after the causing input or frame tick.
module game_flow_ctrl
    import shoot_game_pkg::*;
#(
    parameter int LIVES_INIT       = 3,
    parameter int SCORE_W          = 8,
    parameter int COUNTDOWN_FRAMES = 120,
    parameter int HIT_FRAMES       = 60
) (
    input  logic               board_clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               vsync,
    input  logic               key_valid,
    input  logic [7:0]         key_code,
    input  logic               key_break,
    output logic               key_ready,
    input  logic               shot_done,
    input  logic               hit,
    input  logic               player_hit,
    output logic [2:0]         state,
    output logic               frame_en,
    output logic               move_left,
    output logic               move_right,
    output logic               fire,
    output logic               shot_active,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives
);

    localparam int CNT_MAX = max_int(COUNTDOWN_FRAMES, HIT_FRAMES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_CD_LOAD  = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_HIT_LOAD = CNT_W'(HIT_FRAMES - 1);
    localparam logic [1:0]       LIVES_LOAD   = 2'(LIVES_INIT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [1:0]         r_lives;
    logic               r_shot_active;
    logic               r_fire;
    logic               r_left_held;
    logic               r_right_held;
    logic               r_frame_en;
    logic               r_move_left;
    logic               r_move_right;
    logic               r_key_ready;
    logic               r_vsync_d;
    logic               r_tick;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [1:0]         w_lives_nxt;
    logic               w_shot_nxt;
    logic               w_fire_nxt;
    logic               w_left_nxt;
    logic               w_right_nxt;
    logic               w_frame_nxt;
    logic               w_mleft_nxt;
    logic               w_mright_nxt;
    logic               w_start_rise;
    logic               w_key_acc;
    logic               w_space_press;

    sync_edge_det u_start_sync (
        .clk    (board_clk),
        .rst_n  (reset_n),
        .i_d    (start),
        .o_rise (w_start_rise)
    );

    assign w_key_acc     = key_valid & r_key_ready;
    assign w_space_press = w_key_acc & (key_code == KEY_SPACE) & ~key_break;

    // vsync is active-low: a frame begins on its falling edge.
    always_ff @(posedge board_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_d   <= 1'b0;
            r_tick      <= 1'b0;
            r_key_ready <= 1'b0;
        end else begin
            r_vsync_d   <= vsync;
            r_tick      <= r_vsync_d & ~vsync;
            r_key_ready <= 1'b1;
        end
    end

    always_ff @(posedge board_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_score       <= '0;
            r_lives       <= '0;
            r_shot_active <= 1'b0;
            r_fire        <= 1'b0;
            r_left_held   <= 1'b0;
            r_right_held  <= 1'b0;
            r_frame_en    <= 1'b0;
            r_move_left   <= 1'b0;
            r_move_right  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_score       <= w_score_nxt;
            r_lives       <= w_lives_nxt;
            r_shot_active <= w_shot_nxt;
            r_fire        <= w_fire_nxt;
            r_left_held   <= w_left_nxt;
            r_right_held  <= w_right_nxt;
            r_frame_en    <= w_frame_nxt;
            r_move_left   <= w_mleft_nxt;
            r_move_right  <= w_mright_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_shot_nxt   = r_shot_active;
        w_fire_nxt   = 1'b0;
        w_left_nxt   = 1'b0;
        w_right_nxt  = 1'b0;
        w_frame_nxt  = 1'b0;
        w_mleft_nxt  = 1'b0;
        w_mright_nxt = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_COUNTDOWN;
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES_LOAD;
                    w_cnt_nxt   = CNT_CD_LOAD;
                end
            end

            ST_COUNTDOWN: begin
                if (r_tick) begin
                    if (r_cnt == '0) w_state_nxt = ST_PLAY;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end

            ST_PLAY: begin
                w_left_nxt   = r_left_held;
                w_right_nxt  = r_right_held;
                w_frame_nxt  = r_tick;
                w_mleft_nxt  = r_tick & r_left_held & ~r_right_held;
                w_mright_nxt = r_tick & r_right_held & ~r_left_held;

                if (w_key_acc && key_code == KEY_LEFT)  w_left_nxt  = ~key_break;
                if (w_key_acc && key_code == KEY_RIGHT) w_right_nxt = ~key_break;

                // A shot ending this cycle wins over a new launch request.
                if (w_space_press && !r_shot_active && !shot_done && !hit) begin
                    w_fire_nxt = 1'b1;
                    w_shot_nxt = 1'b1;
                end
                if (shot_done || hit) w_shot_nxt = 1'b0;

                if (hit && !(&r_score)) w_score_nxt = r_score + 1'b1;

                if (player_hit) begin
                    w_fire_nxt  = 1'b0;
                    w_shot_nxt  = 1'b0;
                    w_left_nxt  = 1'b0;
                    w_right_nxt = 1'b0;
                    if (r_lives <= 2'd1) begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_state_nxt = ST_HIT_PAUSE;
                        w_cnt_nxt   = CNT_HIT_LOAD;
                    end
                end
            end

            ST_HIT_PAUSE: begin
                if (r_tick) begin
                    if (r_cnt == '0) w_state_nxt = ST_PLAY;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign key_ready   = r_key_ready;
    assign state       = r_state;
    assign frame_en    = r_frame_en;
    assign move_left   = r_move_left;
    assign move_right  = r_move_right;
    assign fire        = r_fire;
    assign shot_active = r_shot_active;
    assign score       = r_score;
    assign lives       = r_lives;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: flow, frame gating, key handling, shot arbitration, score/lives, reset.
module tb_game_flow_ctrl;
    import shoot_game_pkg::*;

    logic       board_clk  = 1'b0;
    logic       reset_n    = 1'b0;
    logic       start      = 1'b0;
    logic       vsync      = 1'b1;
    logic       key_valid  = 1'b0;
    logic [7:0] key_code   = 8'h00;
    logic       key_break  = 1'b0;
    logic       shot_done  = 1'b0;
    logic       hit        = 1'b0;
    logic       player_hit = 1'b0;

    logic       key_ready;
    logic [2:0] state;
    logic       frame_en;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       shot_active;
    logic [7:0] score;
    logic [1:0] lives;

    int n_checks = 0;
    int n_fail   = 0;

    game_flow_ctrl #(
        .LIVES_INIT       (3),
        .SCORE_W          (8),
        .COUNTDOWN_FRAMES (120),
        .HIT_FRAMES       (60)
    ) dut (
        .board_clk   (board_clk),
        .reset_n     (reset_n),
        .start       (start),
        .vsync       (vsync),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_break   (key_break),
        .key_ready   (key_ready),
        .shot_done   (shot_done),
        .hit         (hit),
        .player_hit  (player_hit),
        .state       (state),
        .frame_en    (frame_en),
        .move_left   (move_left),
        .move_right  (move_right),
        .fire        (fire),
        .shot_active (shot_active),
        .score       (score),
        .lives       (lives)
    );

    always #5 board_clk = ~board_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One vsync fall; outputs sampled on the cycle the tick is consumed.
    task automatic frame(output logic fe, output logic ml, output logic mr);
        vsync = 1'b0;
        @(negedge board_clk);
        vsync = 1'b1;
        @(negedge board_clk);
        fe = frame_en;
        ml = move_left;
        mr = move_right;
    endtask

    task automatic frames(input int n, output int fe_cnt);
        logic fe, ml, mr;
        fe_cnt = 0;
        for (int i = 0; i < n; i++) begin
            frame(fe, ml, mr);
            if (fe) fe_cnt++;
        end
    endtask

    task automatic key(input logic [7:0] c, input logic b);
        key_valid = 1'b1;
        key_code  = c;
        key_break = b;
        @(negedge board_clk);
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (3) @(negedge board_clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int max_cyc);
        for (int i = 0; i < max_cyc && state !== exp; i++) @(negedge board_clk);
        chk(tag, state, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic fe, ml, mr;
        int   fe_cnt;

        // reset state
        repeat (2) @(negedge board_clk);
        chk("rst_state", state, 3'd0);
        chk("rst_key_ready", key_ready, 1'b0);
        chk("rst_score", score, 8'd0);
        chk("rst_lives", lives, 2'd0);
        chk("rst_shot", shot_active, 1'b0);
        reset_n = 1'b1;
        @(negedge board_clk);
        chk("key_ready_after_rst", key_ready, 1'b1);

        // start -> countdown
        press_start();
        wait_state("start_to_cd", ST_COUNTDOWN, 8);
        chk("cd_score", score, 8'd0);
        chk("cd_lives", lives, 2'd3);

        frames(119, fe_cnt);
        chk("cd_no_frame_en", fe_cnt, 0);
        chk("cd_after_119", state, ST_COUNTDOWN);
        frame(fe, ml, mr);
        chk("cd_after_120", state, ST_PLAY);

        // start in PLAY ignored
        press_start();
        repeat (4) @(negedge board_clk);
        chk("start_in_play", state, ST_PLAY);

        // left held for three frames
        key(KEY_LEFT, 1'b0);
        for (int i = 0; i < 3; i++) begin
            frame(fe, ml, mr);
            chk("left_fe", fe, 1'b1);
            chk("left_ml", ml, 1'b1);
            chk("left_mr", mr, 1'b0);
        end
        key(KEY_LEFT, 1'b1);
        frame(fe, ml, mr);
        chk("left_brk_fe", fe, 1'b1);
        chk("left_brk_ml", ml, 1'b0);
        key(KEY_LEFT, 1'b0);
        key(KEY_RIGHT, 1'b0);
        frame(fe, ml, mr);
        chk("both_ml", ml, 1'b0);
        chk("both_mr", mr, 1'b0);
        key(KEY_LEFT, 1'b1);
        frame(fe, ml, mr);
        chk("right_only_mr", mr, 1'b1);
        chk("right_only_ml", ml, 1'b0);
        key(KEY_RIGHT, 1'b1);

        // shot arbitration
        key(KEY_SPACE, 1'b0);
        chk("fire_pulse", fire, 1'b1);
        chk("shot_set", shot_active, 1'b1);
        @(negedge board_clk);
        chk("fire_one_cycle", fire, 1'b0);
        key(KEY_SPACE, 1'b0);
        chk("fire_busy", fire, 1'b0);
        shot_done = 1'b1;
        @(negedge board_clk);
        shot_done = 1'b0;
        chk("shot_done_clr", shot_active, 1'b0);
        key_valid = 1'b1; key_code = KEY_SPACE; key_break = 1'b0; shot_done = 1'b1;
        @(negedge board_clk);
        key_valid = 1'b0; shot_done = 1'b0;
        chk("space_done_fire", fire, 1'b0);
        chk("space_done_shot", shot_active, 1'b0);

        // hit and player_hit together
        hit = 1'b1; player_hit = 1'b1;
        @(negedge board_clk);
        hit = 1'b0; player_hit = 1'b0;
        chk("hp_score", score, 8'd1);
        chk("hp_lives", lives, 2'd2);
        chk("hp_state", state, ST_HIT_PAUSE);
        hit = 1'b1;
        @(negedge board_clk);
        hit = 1'b0;
        chk("pause_hit_ignored", score, 8'd1);
        frames(59, fe_cnt);
        chk("pause_no_frame_en", fe_cnt, 0);
        chk("pause_after_59", state, ST_HIT_PAUSE);
        frame(fe, ml, mr);
        chk("pause_after_60", state, ST_PLAY);

        // score saturation
        hit = 1'b1;
        repeat (3) @(negedge board_clk);
        hit = 1'b0;
        chk("score_4", score, 8'd4);
        hit = 1'b1;
        repeat (300) @(negedge board_clk);
        hit = 1'b0;
        chk("score_sat", score, 8'd255);

        // remaining lives
        player_hit = 1'b1;
        @(negedge board_clk);
        player_hit = 1'b0;
        chk("lives_1", lives, 2'd1);
        chk("ph2_state", state, ST_HIT_PAUSE);
        frames(60, fe_cnt);
        chk("back_to_play", state, ST_PLAY);
        player_hit = 1'b1;
        @(negedge board_clk);
        player_hit = 1'b0;
        chk("lives_0", lives, 2'd0);
        chk("game_over", state, ST_GAME_OVER);
        chk("go_score_held", score, 8'd255);

        // restart from game over
        press_start();
        wait_state("restart_cd", ST_COUNTDOWN, 8);
        chk("restart_score", score, 8'd0);
        chk("restart_lives", lives, 2'd3);
        frames(120, fe_cnt);
        chk("restart_play", state, ST_PLAY);

        // async reset mid-play with a shot in flight
        hit = 1'b1;
        @(negedge board_clk);
        hit = 1'b0;
        key(KEY_SPACE, 1'b0);
        chk("pre_rst_shot", shot_active, 1'b1);
        chk("pre_rst_score", score, 8'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", state, 3'd0);
        chk("arst_shot", shot_active, 1'b0);
        chk("arst_score", score, 8'd0);
        chk("arst_lives", lives, 2'd0);
        chk("arst_key_ready", key_ready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
